// File: rtl/muldiv_pkg.sv
// Opcode encodings, state encodings and class-decode helpers shared by the
// HI/LO multiply/divide engine and its divider core.
package muldiv_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_start(input logic [3:0] op);
    return is_mul(op) || is_div(op);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Bit-serial restoring divider on unsigned magnitudes, one quotient bit per
// cycle; the load cycle already performs the first step.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_done
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  logic [WIDTH-1:0] w_rem_in, w_quo_in, w_dvs_in, w_rem_nxt, w_quo_nxt;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;

  always_comb begin
    w_rem_in  = i_load ? '0 : r_rem;
    w_quo_in  = i_load ? i_dividend : r_quo;
    w_dvs_in  = i_load ? i_divisor : r_dvs;
    // Borrow out of the (WIDTH+1)-bit subtract means the trial did not fit.
    w_trial   = {w_rem_in, w_quo_in[WIDTH-1]} - {1'b0, w_dvs_in};
    w_ge      = ~w_trial[WIDTH];
    w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : {w_rem_in[WIDTH-2:0], w_quo_in[WIDTH-1]};
    w_quo_nxt = {w_quo_in[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_dvs <= i_divisor;
      r_cnt <= CNT_W'(WIDTH - 1);
      r_run <= 1'b1;
    end else if (r_cnt != '0) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_quo  = r_quo;
  assign o_rem  = r_rem;
  assign o_done = r_run & (r_cnt == '0);

endmodule

// File: rtl/hilo_muldiv_engine.sv
// Multi-cycle multiply/divide/accumulate unit owning the HI/LO pair; EX stalls
// on o_busy and reads HI/LO back through o_rdata.
module hilo_muldiv_engine
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [3:0]       i_op,
  input  logic             i_op_valid,
  input  logic             i_cancel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_start,
  output logic [WIDTH-1:0] o_rdata,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic               r_neg_q, r_neg_r, r_dz, r_ovf;

  logic               w_busy, w_accept, w_start, w_sgn_in, w_sgn_r, w_commit;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_div_hi, w_div_lo;
  logic               w_div_done;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod, w_mul_res;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = i_op_valid & ~i_cancel & ~w_busy;
  assign w_start  = w_accept & is_start(i_op);
  assign w_sgn_in = is_signed_op(i_op);
  assign w_mag_a  = (w_sgn_in & i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b  = (w_sgn_in & i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_commit = w_busy & (r_cnt == CNT_W'(1)) & ~i_cancel;

  muldiv_div_core #(.WIDTH(WIDTH)) u_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_start & is_div(i_op)),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quo      (w_quo),
    .o_rem      (w_rem),
    .o_done     (w_div_done)
  );

  // Sign-extend to 2*WIDTH so one truncated multiply serves both signednesses.
  assign w_sgn_r = is_signed_op(r_op);
  assign w_ext_a = {{WIDTH{w_sgn_r & r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = {{WIDTH{w_sgn_r & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_comb begin
    w_mul_res = w_prod;
    if (r_op == OP_MADD || r_op == OP_MADDU)
      w_mul_res = {r_hi, r_lo} + w_prod;
    else if (r_op == OP_MSUB || r_op == OP_MSUBU)
      w_mul_res = {r_hi, r_lo} - w_prod;
  end

  always_comb begin
    w_div_lo = r_neg_q ? -w_quo : w_quo;
    w_div_hi = r_neg_r ? -w_rem : w_rem;
    if (r_dz) begin
      w_div_lo = '1;
      w_div_hi = r_a;
    end else if (r_ovf) begin
      w_div_lo = MOST_NEG;
      w_div_hi = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = is_mul(i_op) ? ST_MUL : ST_DIV;
      ST_MUL, ST_DIV: if (i_cancel || r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_op    <= OP_NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (!w_busy) begin
      if (w_start) begin
        r_cnt   <= is_mul(i_op) ? CNT_W'(MUL_LAT) : CNT_W'(WIDTH);
        r_op    <= i_op;
        r_a     <= i_a;
        r_b     <= i_b;
        r_neg_q <= w_sgn_in & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_neg_r <= w_sgn_in & i_a[WIDTH-1];
        r_dz    <= (i_b == '0);
        r_ovf   <= w_sgn_in & (i_a == MOST_NEG) & (i_b == '1);
      end
    end else if (i_cancel) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit && r_state == ST_MUL) begin
      {r_hi, r_lo} <= w_mul_res;
    end else if (w_commit && r_state == ST_DIV && w_div_done) begin
      r_hi <= w_div_hi;
      r_lo <= w_div_lo;
    end else if (w_accept && i_op == OP_MTHI) begin
      r_hi <= i_a;
    end else if (w_accept && i_op == OP_MTLO) begin
      r_lo <= i_a;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_op == OP_MFHI)      o_rdata = r_hi;
    else if (i_op == OP_MFLO) o_rdata = r_lo;
  end

  assign o_busy  = w_busy;
  assign o_start = w_start;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: doc/hilo_muldiv_engine.md
Name: hilo_muldiv_engine

Overview:
- Parametrised multi-cycle multiply/divide unit with an architectural HI/LO register pair.
- Sits in the EX stage beside the ALU. EX drives operands and a decoded HI/LO opcode; the stall logic reads busy; mfhi/mflo data returns through rdata into the EX result mux.
- Over the previous fixed-width unit it adds:
  - width and multiply-latency parameters
  - a bit-serial divider
  - multiply-accumulate/subtract (madd/msub)
  - an exception cancel that aborts an in-flight operation without corrupting HI/LO

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 8.
- MUL_LAT, 5, cycles from mult/madd/msub accept to HI/LO commit; minimum 1.
- DIV_LAT, WIDTH, cycles from div accept to commit; fixed by the bit-serial core at one quotient bit per cycle; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- op  in  4  HI/LO opcode (encoding in package); 0 = none.
- op_valid  in  1  op and operands are valid this cycle.
- cancel  in  1  exception flush; kills the current request and any in-flight operation.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  operation in flight; stall qualifier.
- start  out  1  combinational; a start-class op is accepted this cycle.
- rdata  out  WIDTH  combinational; HI for MFHI, LO for MFLO, else 0.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.

Behaviour:
- Reset: HI = 0, LO = 0, busy = 0, counter = 0, state IDLE. Takes effect immediately (asynchronous) and aborts any operation.
- Opcode classes:
  - start-class: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU
  - move-class: MTHI, MTLO
  - read-class: MFHI, MFLO
- Accept rule: accept = op_valid & ~cancel & ~busy. start = accept & start-class.
- State machine IDLE -> MUL or DIV -> IDLE:
  - IDLE: on start, latch the operands and opcode, load the counter (MUL_LAT for multiply-class, WIDTH for divide-class), set busy = 1 on the next edge.
  - MUL/DIV: decrement the counter each cycle. On the cycle the counter reaches 1, the next edge writes HI/LO and clears busy to 0.
  - Latency: new HI/LO become visible exactly MUL_LAT (multiply-class) or WIDTH (divide-class) cycles after the accept edge.
- MUL: the 2*WIDTH product is computed from the latched operands, signed for MULT/MADD/MSUB and unsigned for the U variants, then held through a delay counter. No shift-add loop is required.
- Accumulate:
  - MADD*: {HI,LO} <= {HI,LO} + product.
  - MSUB*: {HI,LO} <= {HI,LO} - product.
  - Both wrap modulo 2^(2*WIDTH).
  - {HI,LO} is sampled at commit, not at accept.
- DIV: bit-serial restoring division on magnitudes; signs are fixed up at commit.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = a. No trap.
- Signed overflow (a = most negative, b = -1): LO = most negative, HI = 0.
- MTHI/MTLO: on accept, HI or LO <= a at the next edge. Never started while busy (the accept rule drops them; the pipeline stalls them).
- MFHI/MFLO: rdata reflects the register value in the same cycle. While busy it returns the pre-operation value; stall logic must hold the reader off until busy falls.
- cancel while busy: the next edge returns to IDLE and clears busy; HI/LO are unchanged. A cancel on the commit cycle also suppresses the write.
- cancel with a start in the same cycle: no start, start = 0. Cancel also blocks MT writes.
- The op input is ignored while busy; only cancel is observed.

Decomposition:
- Package muldiv_pkg holds:
  - opcode localparams: NONE = 0, MULT = 1, MULTU = 2, DIV = 3, DIVU = 4, MFHI = 5, MFLO = 6, MTHI = 7, MTLO = 8, MADD = 9, MADDU = 10, MSUB = 11, MSUBU = 12
  - class-decode functions is_start, is_mul, is_div
  - state encodings IDLE/MUL/DIV
- One sub-module: muldiv_div_core (bit-serial restoring divider).
  - Interface: load, magnitudes in, quotient/remainder out, done after WIDTH cycles.
  - Sign fixup and the divide-by-zero and signed-overflow rules stay in the top.

Test Plan (WIDTH = 32, MUL_LAT = 5):
- Reset, then MTHI a=0x12345678 and MTLO a=0x9ABCDEF0 -> hi/lo match one cycle later; MFHI/MFLO rdata match with busy = 0 throughout.
- MULT a=0xFFFFFFFE (-2), b=3 -> start pulses; busy = 1 for exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV a=-7, b=2 -> busy 32 cycles; then LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU a=7, b=0 -> LO = 0xFFFFFFFF, HI = 7. DIV a=0x80000000, b=-1 -> LO = 0x80000000, HI = 0.
- HI=0, LO=0xFFFFFFFF, MADDU a=1, b=1 -> HI = 1, LO = 0. Then MSUB a=1, b=1 -> HI = 0, LO = 0xFFFFFFFF.
- DIV started, cancel on cycle 10 -> busy = 0 next cycle, HI/LO unchanged. MULT with cancel asserted the same cycle -> start = 0, busy never rises.
- MTLO offered while busy -> LO unchanged. Async reset pulsed mid-DIV -> busy = 0, HI = LO = 0 immediately without a clock edge.
